seq_add96_ctrl: RTL and testbench

SEQ_ADD96_CTRL -- requirements
Module: seq_add96_ctrl

---
 rtl/add96_pkg.sv | 17 +
 rtl/add24_pg.sv | 76 +++++++
 rtl/seq_add96_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_add96_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add96_pkg.sv
// Shared widths, slice count and FSM encoding for the sequential 96-bit adder.
package add96_pkg;

    localparam int DATA_W_DEF     = 96;
    localparam int SLICE_W_DEF    = 24;
    localparam int NUM_SLICES_DEF = DATA_W_DEF / SLICE_W_DEF;

    // Number of propagate/generate groups inside one slice adder.
    localparam int PG_GROUPS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/add24_pg.sv
// One slice adder: four propagate/generate groups joined by a two-level
// carry lookahead. Ripple is confined to the bits inside a single group.
module add24_pg
    import add96_pkg::*;
#(
    parameter int W = SLICE_W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_in,
    output logic [W-1:0] sum_o,
    output logic         c_out
);

    localparam int GW = W / PG_GROUPS;

    logic [W-1:0]         p;
    logic [W-1:0]         g;
    logic [PG_GROUPS-1:0] grp_p;
    logic [PG_GROUPS-1:0] grp_g;
    logic [PG_GROUPS:0]   grp_c;
    logic                 rc;

    if (W % PG_GROUPS != 0) begin : g_bad_width
        $error("add24_pg: W must be a multiple of PG_GROUPS");
    end

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Collapse each group's bits into a group propagate and group generate.
    always_comb begin
        grp_p = '1;
        grp_g = '0;
        for (int k = 0; k < PG_GROUPS; k++) begin
            for (int j = 0; j < GW; j++) begin
                grp_g[k] = g[k*GW + j] | (p[k*GW + j] & grp_g[k]);
                grp_p[k] = grp_p[k] & p[k*GW + j];
            end
        end
    end

    // Lookahead: every group carry-in is a flat function of c_in and the
    // group P/G terms, so no carry ripples from one group into the next.
    assign grp_c[0] = c_in;
    assign grp_c[1] = grp_g[0]
                    | (grp_p[0] & c_in);
    assign grp_c[2] = grp_g[1]
                    | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & c_in);
    assign grp_c[3] = grp_g[2]
                    | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);
    assign grp_c[4] = grp_g[3]
                    | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_in);

    // Sum bits, rippling only within a group from its lookahead carry-in.
    always_comb begin
        sum_o = '0;
        rc    = 1'b0;
        for (int k = 0; k < PG_GROUPS; k++) begin
            rc = grp_c[k];
            for (int j = 0; j < GW; j++) begin
                sum_o[k*GW + j] = p[k*GW + j] ^ rc;
                rc              = g[k*GW + j] | (p[k*GW + j] & rc);
            end
        end
    end

    assign c_out = grp_c[PG_GROUPS];

endmodule

// File: rtl/seq_add96_ctrl.sv
// Sequential wide adder/subtractor: one SLICE_W slice per RUN cycle through a
// single shared lookahead slice adder, carry held in a register between slices.
module seq_add96_ctrl
    import add96_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = DATA_W / SLICE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_out,
    output logic              c_out,
    output logic              busy
);

    // state   | meaning
    // IDLE    | waiting for operands, in_ready high
    // RUN     | adding slice idx_q, carry chained through carry_q
    // DONE    | result held on sum_out/c_out until out_ready

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if (DATA_W != NUM_SLICES * SLICE_W) begin : g_bad_slicing
        $error("seq_add96_ctrl: DATA_W must equal NUM_SLICES * SLICE_W");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                cout_q, cout_d;

    logic [SLICE_W-1:0]  a_sl;
    logic [SLICE_W-1:0]  b_sl;
    logic [SLICE_W-1:0]  sl_sum;
    logic                sl_cout;

    assign a_sl = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign b_sl = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

    add24_pg #(
        .W (SLICE_W)
    ) u_slice (
        .a_i   (a_sl),
        .b_i   (b_sl),
        .c_in  (carry_q),
        .sum_o (sl_sum),
        .c_out (sl_cout)
    );

    // Next-state and datapath updates; B is stored pre-inverted for subtract
    // so RUN never needs to look at the operation again.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q) * SLICE_W +: SLICE_W] = sl_sum;
                carry_d = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum_out   = sum_q;
    assign c_out     = cout_q;

endmodule

// File: tb/tb_seq_add96_ctrl.sv
// Bench for seq_add96_ctrl: directed corner cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_seq_add96_ctrl;
    import add96_pkg::*;

    localparam int DW = 96;
    localparam int NS = NUM_SLICES_DEF;
    // Accept-to-accept spacing: NS RUN cycles, one DONE cycle, one IDLE cycle.
    localparam int ISSUE_GAP = NS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op_sub = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum_out;
    logic          c_out;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_add96_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Reference: unbounded-integer add, or subtract with no-borrow = (a >= b).
    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic sub, output logic [DW-1:0] s, output logic c);
        logic [DW:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b};
            s = r[DW-1:0];
            c = r[DW];
        end else begin
            s = a - b;
            c = (a >= b);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sub, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op_sub   = sub;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a_in     = rand96();
        b_in     = rand96();
        op_sub   = 1'($urandom);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sub, input int stall, input string tag,
                          output int acc_cyc);
        logic [DW-1:0] es;
        logic          ec;
        int            lat;
        model(a, b, sub, es, ec);
        issue(a, b, sub, acc_cyc);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            a_in      = rand96();
            b_in      = rand96();
            op_sub    = 1'($urandom);
            step();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        checks++;
        if (lat != NS) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", tag, lat, NS);
        end
        checks++;
        if (sum_out !== es) begin
            errors++;
            $display("FAIL %s sum: got %h required %h", tag, sum_out, es);
        end
        checks++;
        if (c_out !== ec) begin
            errors++;
            $display("FAIL %s c_out: got %b required %b", tag, c_out, ec);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a_in     = rand96();
            b_in     = rand96();
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_out !== es || c_out !== ec) begin
                errors++;
                $display("FAIL %s hold[%0d]: out_valid=%b in_ready=%b sum=%h c=%b required 1 0 %h %b",
                         tag, i, out_valid, in_ready, sum_out, c_out, es, ec);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     tag, out_valid, in_ready, busy);
        end
        out_ready = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            sum_out !== '0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%b busy=%b out_valid=%b sum=%h c=%b required 1 0 0 0 0",
                     tag, in_ready, busy, out_valid, sum_out, c_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        check_reset_outputs("reset_low");
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_directed();
        int acc;
        run_op(96'h1, {DW{1'b1}}, 1'b0, 0, "add_wrap", acc);
        checks++;
        if (sum_out !== '0 || c_out !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap_const: sum=%h c=%b required 0 1", sum_out, c_out);
        end
        run_op(96'h10, 96'h11, 1'b1, 0, "sub_neg", acc);
        checks++;
        if (sum_out !== {DW{1'b1}} || c_out !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg_const: sum=%h c=%b required all-ones 0", sum_out, c_out);
        end
        run_op(96'h11, 96'h10, 1'b1, 0, "sub_pos", acc);
        checks++;
        if (sum_out !== 96'h1 || c_out !== 1'b1) begin
            errors++;
            $display("FAIL sub_pos_const: sum=%h c=%b required 1 1", sum_out, c_out);
        end
        run_op(96'h00FF_FFFF, 96'h1, 1'b0, 0, "slice_carry", acc);
        checks++;
        if (sum_out !== 96'h0100_0000 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL slice_carry_const: sum=%h c=%b required 01000000 0", sum_out, c_out);
        end
        run_op({DW{1'b1}}, {DW{1'b1}}, 1'b1, 0, "sub_equal", acc);
    endtask

    task automatic test_stall();
        int acc;
        run_op(rand96(), rand96(), 1'b0, 10, "stall10_add", acc);
        run_op(rand96(), rand96(), 1'b1, 10, "stall10_sub", acc);
    endtask

    task automatic test_reset_mid_op();
        int acc;
        int seen;
        issue(96'h1234_5678, 96'h9abc, 1'b0, acc);
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_run_discard: out_valid seen %0d cycles required 0", seen);
        end
        run_op(96'h5, 96'h7, 1'b0, 0, "after_reset_run", acc);
        checks++;
        if (sum_out !== 96'd12) begin
            errors++;
            $display("FAIL after_reset_const: sum=%h required c", sum_out);
        end

        issue(rand96(), rand96(), 1'b1, acc);
        out_ready = 1'b0;
        for (int i = 0; i < NS + 2; i++) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_done");
        step();
        rst_n = 1'b1;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_done_discard: out_valid seen %0d cycles required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int            acc;
        int            prev;
        int            bad_gap;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] mask;
        logic          sub;
        prev    = -1;
        bad_gap = 0;
        for (int i = 0; i < 10000; i++) begin
            a    = rand96();
            b    = rand96();
            mask = rand96();
            sub  = 1'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: b = sub ? a : ~a;
                2: begin a = a | mask; b = sub ? (a & ~mask) : 96'h1; end
                default: begin a = {64'h0, $urandom}; b = {64'h0, $urandom}; end
            endcase
            run_op(a, b, sub, 0, "b2b", acc);
            if (prev >= 0 && (acc - prev) != ISSUE_GAP) begin
                if (bad_gap == 0)
                    $display("FAIL b2b_gap: accept spacing %0d required %0d", acc - prev, ISSUE_GAP);
                bad_gap++;
            end
            prev = acc;
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_gap_total: bad spacings %0d required 0", bad_gap);
        end
    endtask

    task automatic test_random_stall();
        int acc;
        for (int i = 0; i < 200; i++) begin
            run_op(rand96(), rand96(), 1'($urandom), $urandom_range(0, 4), "rand_stall", acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_op();
        test_back_to_back();
        test_random_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
